// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory. Packs bytes little-endian into
// 32-bit words, writes them to sequential addresses and holds the core in reset until done.
module imem_loader #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W:0]   len_words,
   input  logic              s_valid,
   input  logic [7:0]        s_data,
   output logic              s_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_reset,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

   logic [1:0]        state_q, state_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
   logic [1:0]        byte_cnt_q, byte_cnt_d;
   logic [31:0]       word_q, word_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              err_q, err_d;
   logic              len_ok;

   assign len_ok = (len_words != '0) && (len_words <= CAP);

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      word_cnt_d = word_cnt_q;
      byte_cnt_d = byte_cnt_q;
      word_d     = word_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      err_d      = err_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               if (len_ok) begin
                  len_d      = len_words;
                  word_cnt_d = '0;
                  byte_cnt_d = '0;
                  err_d      = 1'b0;
                  state_d    = S_LOAD;
               end else begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end
            end
         end
         S_LOAD: begin
            if (start) err_d = 1'b1;
            // s_ready is high throughout LOAD, so s_valid alone means a transfer
            if (s_valid) begin
               word_d[8*byte_cnt_q +: 8] = s_data;
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  wdata_d = {s_data, word_q[23:0]};
                  addr_d  = word_cnt_q[ADDR_W-1:0];
                  state_d = S_WRITE;
               end
            end
         end
         default: begin
            if (start) err_d = 1'b1;
            word_cnt_d = word_cnt_q + ONE;
            state_d    = (word_cnt_q + ONE == len_q) ? S_DONE : S_LOAD;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         len_q      <= '0;
         word_cnt_q <= '0;
         byte_cnt_q <= '0;
         word_q     <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         word_cnt_q <= word_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         word_q     <= word_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         err_q      <= err_d;
      end
   end

   assign s_ready    = (state_q == S_LOAD);
   assign imem_we    = (state_q == S_WRITE);
   assign busy       = (state_q == S_LOAD) || (state_q == S_WRITE);
   assign done       = (state_q == S_DONE);
   assign core_reset = (state_q != S_DONE);
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign err        = err_q;

endmodule
